// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, 32 steps plus a sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [63:0] p_q, p_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        isdiv_q, isdiv_d;
  logic        negp_q, negp_d;
  logic        negr_q, negr_d;
  logic        div0_q, div0_d;

  logic        is_mul, is_dv, is_mthi, is_mtlo, sgn;
  logic [31:0] mag1, mag2;
  logic [32:0] madd, rsh, rsub;
  logic        rge;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign is_mul  = (funct == F_MULT) || (funct == F_MULTU);
  assign is_dv   = (funct == F_DIV) || (funct == F_DIVU);
  assign is_mthi = (funct == F_MTHI);
  assign is_mtlo = (funct == F_MTLO);
  assign sgn     = (funct == F_MULT) || (funct == F_DIV);

  assign mag1 = (sgn && op1[31]) ? -op1 : op1;
  assign mag2 = (sgn && op2[31]) ? -op2 : op2;

  // p_q holds {acc, multiplier} for MUL and {rem, quotient} for DIV
  assign madd = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? a_q : 32'd0)};
  assign rsh  = {p_q[63:32], p_q[31]};
  assign rsub = rsh - {1'b0, a_q};
  assign rge  = ~rsub[32];

  assign prod = negp_q ? -p_q : p_q;
  assign quo  = div0_q ? 32'hFFFF_FFFF
              : (negp_q ? -p_q[31:0] : p_q[31:0]);
  assign rem  = negr_q ? -p_q[63:32] : p_q[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    isdiv_d = isdiv_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              a_d     = mag1;
              p_d     = {32'd0, mag2};
              negp_d  = sgn & (op1[31] ^ op2[31]);
              negr_d  = 1'b0;
              div0_d  = 1'b0;
              isdiv_d = 1'b0;
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = MUL;
            end
            is_dv: begin
              a_d     = mag2;
              p_d     = {32'd0, mag1};
              negp_d  = sgn & (op1[31] ^ op2[31]);
              negr_d  = sgn & op1[31];
              div0_d  = (op2 == 32'd0);
              isdiv_d = 1'b1;
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = DIV;
            end
            is_mthi: hi_d = op1;
            is_mtlo: lo_d = op1;
            default: ;
          endcase
        end
      end
      MUL: begin
        p_d   = {madd, p_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      DIV: begin
        p_d   = rge ? {rsub[31:0], p_q[30:0], 1'b1}
                    : {rsh[31:0], p_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (isdiv_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      isdiv_q <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      isdiv_q <= isdiv_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit.
// Reference model uses plain 64-bit arithmetic.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    sa = a; sb = b; h = '0; l = '0;
    case (f)
      6'd24: begin
        p = longint'(sa) * longint'(sb);
        h = p[63:32]; l = p[31:0];
      end
      6'd25: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32]; l = p[31:0];
      end
      6'd26: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = a; h = '0;
        end else begin l = sa / sb; h = sa % sb; end
      end
      6'd27: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Caller is at a negedge; returns at the negedge after done rises.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [31:0] h, output logic [31:0] l);
    start = 1'b1; funct = f; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0; op1 = $urandom; op2 = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    h = hi; l = lo;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; funct = 6'd17;
    op1 = 32'hDEAD_BEEF; op2 = 32'h1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want all 0",
               busy, done, hi, lo);
    end
    reset_n = 1'b1; start = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk);
  endtask

  task automatic test_mt();
    logic [31:0] x;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      funct = (i % 2 == 0) ? 6'd17 : 6'd19;
      start = 1'b1; op1 = x; op2 = $urandom;
      @(negedge clk);
      start = 1'b0;
      if (i % 2 == 0) mhi = x; else mlo = x;
      total++;
      if (hi !== mhi || lo !== mlo || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL mthi_mtlo: hi=%h lo=%h b=%b d=%b want hi=%h lo=%h 0 0",
                 hi, lo, busy, done, mhi, mlo);
      end
    end
  endtask

  task automatic test_bad_funct();
    logic [5:0] fs [5];
    fs[0] = 6'd0; fs[1] = 6'd16; fs[2] = 6'd18;
    fs[3] = 6'd28; fs[4] = 6'd63;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; funct = fs[i]; op1 = $urandom; op2 = $urandom;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      total++;
      if (hi !== mhi || lo !== mlo || busy !== 1'b0) begin
        bad++;
        $display("FAIL bad_funct %0d: hi=%h lo=%h busy=%b want %h %h 0",
                 fs[i], hi, lo, busy, mhi, mlo);
      end
    end
  endtask

  task automatic test_latency();
    int eb, ed, eh;
    eb = 0; ed = 0; eh = 0;
    start = 1'b1; funct = 6'd25; op1 = '1; op2 = '1;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      start = 1'b0; op1 = $urandom; op2 = $urandom;
      if (busy !== (k <= 32)) eb++;
      if (done !== (k == 33)) ed++;
      if (k < 33 && (hi !== mhi || lo !== mlo)) eh++;
    end
    mhi = 32'hFFFF_FFFE; mlo = 32'h1;
    total++;
    if (eb != 0) begin bad++; $display("FAIL lat_busy: %0d bad cycles want 0", eb); end
    total++;
    if (ed != 0) begin bad++; $display("FAIL lat_done: %0d bad cycles want 0", ed); end
    total++;
    if (eh != 0) begin bad++; $display("FAIL lat_hold: %0d bad cycles want 0", eh); end
    total++;
    if (hi !== mhi || lo !== mlo) begin
      bad++;
      $display("FAIL lat_result: hi=%h lo=%h want %h %h", hi, lo, mhi, mlo);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  tf [8];
    logic [31:0] ta [8], tb [8], th [8], tl [8];
    logic [31:0] h, l;
    int lat;
    tf[0]=24; ta[0]=32'hFFFF_FFFD; tb[0]=5;  th[0]=32'hFFFF_FFFF; tl[0]=32'hFFFF_FFF1;
    tf[1]=24; ta[1]=32'h8000_0000; tb[1]=32'h8000_0000; th[1]=32'h4000_0000; tl[1]=0;
    tf[2]=26; ta[2]=32'hFFFF_FFF9; tb[2]=2;  th[2]=32'hFFFF_FFFF; tl[2]=32'hFFFF_FFFD;
    tf[3]=27; ta[3]=7; tb[3]=0;              th[3]=7; tl[3]=32'hFFFF_FFFF;
    tf[4]=26; ta[4]=32'h8000_0000; tb[4]=32'hFFFF_FFFF; th[4]=0; tl[4]=32'h8000_0000;
    tf[5]=27; ta[5]=32'hFFFF_FFFF; tb[5]=32'h10; th[5]=32'hF; tl[5]=32'h0FFF_FFFF;
    tf[6]=26; ta[6]=32'hFFFF_FFFB; tb[6]=0;  th[6]=32'hFFFF_FFFB; tl[6]=32'hFFFF_FFFF;
    tf[7]=25; ta[7]=32'hFFFF_FFFF; tb[7]=32'hFFFF_FFFF; th[7]=32'hFFFF_FFFE; tl[7]=1;
    for (int i = 0; i < 8; i++) begin
      run_op(tf[i], ta[i], tb[i], lat, h, l);
      mhi = th[i]; mlo = tl[i];
      total++;
      if (h !== th[i] || l !== tl[i] || lat != 33) begin
        bad++;
        $display("FAIL directed %0d: hi=%h lo=%h lat=%0d want %h %h 33",
                 i, h, l, lat, th[i], tl[i]);
      end
    end
  endtask

  task automatic test_ignore();
    int k;
    start = 1'b1; funct = 6'd26; op1 = 100; op2 = 7;
    @(negedge clk);
    start = 1'b0; op1 = $urandom; op2 = $urandom;
    k = 0;
    repeat (5) begin @(negedge clk); k++; end
    start = 1'b1; funct = 6'd17; op1 = 32'hAAAA;
    @(negedge clk); k++;
    funct = 6'd24; op1 = 3; op2 = 3;
    @(negedge clk); k++;
    start = 1'b0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    mhi = 2; mlo = 14;
    total++;
    if (hi !== 32'd2 || lo !== 32'd14 || k != 33) begin
      bad++;
      $display("FAIL ignore_busy: hi=%h lo=%h lat=%0d want 2 e 33", hi, lo, k);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; funct = 6'd26; op1 = 100; op2 = 7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mhi = '0; mlo = '0;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_abort: %0d cycles with done/hi/lo set want 0", seen);
    end
    start = 1'b1; funct = 6'd17; op1 = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    mhi = 32'h1234_5678;
    total++;
    if (hi !== mhi || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mthi: hi=%h lo=%h want %h 0", hi, lo, mhi);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l, eh, el;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(6'd27, 32'd1000 + i, 32'd3, lat, h, l);
      model(6'd27, 32'd1000 + i, 32'd3, eh, el);
      mhi = eh; mlo = el;
      total++;
      if (h !== eh || l !== el || lat != 33) begin
        bad++;
        $display("FAIL back_to_back %0d: hi=%h lo=%h lat=%0d want %h %h 33",
                 i, h, l, lat, eh, el);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  f;
    logic [31:0] a, b, h, l, eh, el;
    int lat;
    for (int i = 0; i < 60; i++) begin
      f = 6'(24 + $urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(f, a, b, lat, h, l);
      model(f, a, b, eh, el);
      mhi = eh; mlo = el;
      total++;
      if (h !== eh || l !== el || lat != 33) begin
        bad++;
        $display("FAIL random f=%0d a=%h b=%h: hi=%h lo=%h lat=%0d want %h %h 33",
                 f, a, b, h, l, lat, eh, el);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; funct = '0; op1 = '0; op2 = '0;
    @(negedge clk);
    test_reset();
    test_mt();
    test_bad_funct();
    test_latency();
    test_directed();
    @(negedge clk);
    test_ignore();
    @(negedge clk);
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
